// File: rtl/sonic_dma_desc_fetch.sv
// Descriptor fetch engine: issues burst reads of 4-DW descriptors from the RC table and
// tracks completions. Optional completion watchdog enabled by SONIC_DESC_FETCH_TIMEOUT_EN.
module sonic_dma_desc_fetch #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TO_CYCLES = 65535
) (
  input  logic        i_clk_in,
  input  logic        i_rst,
  input  logic        i_init,
  input  logic [15:0] i_dt_size,
  input  logic [63:0] i_dt_base_rc,
  input  logic [15:0] i_dt_rc_last,
  output logic        o_rd_req,
  input  logic        i_rd_ack,
  output logic [63:0] o_rd_addr,
  output logic [9:0]  o_rd_len_dw,
  output logic        o_rd_3dw,
  input  logic        i_cpl_desc_valid,
  output logic [15:0] o_ep_last,
  output logic        o_ep_last_upd,
  output logic        o_err_unexp_cpl,
  output logic        o_timeout_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitCpl} state_t;

  localparam logic [16:0] MaxBurst = 17'(MAX_BURST);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_last_fetched, w_last_fetched_nxt;
  logic [15:0] r_next, w_next_nxt;
  logic [5:0]  r_count, w_count_nxt;
  logic [5:0]  r_rcv, w_rcv_nxt;
  logic        r_rd_req, w_rd_req_nxt;
  logic [63:0] r_rd_addr, w_rd_addr_nxt;
  logic [9:0]  r_rd_len_dw, w_rd_len_dw_nxt;
  logic        r_rd_3dw, w_rd_3dw_nxt;
  logic [15:0] r_ep_last, w_ep_last_nxt;
  logic        r_ep_last_upd, w_ep_last_upd_nxt;
  logic        r_err_unexp, w_err_unexp_nxt;

  // Burst sizing for the next fetch, evaluated from the live table pointers in IDLE
  logic [15:0] w_next;
  logic [16:0] w_to_end, w_raw, w_clamp1, w_clamp2;
  logic [5:0]  w_count;
  logic [63:0] w_addr;
  logic [5:0]  w_rcv_inc;
  logic [15:0] w_done_idx;

  assign w_next    = (r_last_fetched >= i_dt_size) ? 16'd0 : r_last_fetched + 16'd1;
  assign w_to_end  = {1'b0, i_dt_size} - {1'b0, w_next} + 17'd1;
  assign w_raw     = (w_next <= i_dt_rc_last) ? ({1'b0, i_dt_rc_last} - {1'b0, w_next} + 17'd1)
                                              : w_to_end;
  assign w_clamp1  = (w_raw > w_to_end) ? w_to_end : w_raw;
  assign w_clamp2  = (w_clamp1 > MaxBurst) ? MaxBurst : w_clamp1;
  assign w_count   = 6'(w_clamp2);
  assign w_addr    = i_dt_base_rc + 64'd16 + ({48'd0, w_next} << 4);
  assign w_rcv_inc = r_rcv + 6'd1;
  assign w_done_idx = r_next + {10'd0, r_count} - 16'd1;

`ifdef SONIC_DESC_FETCH_TIMEOUT_EN
  logic [31:0] r_to_cnt, w_to_cnt_nxt;
  logic        r_timeout_err, w_timeout_err_nxt;
  assign o_timeout_err = r_timeout_err;
`else
  logic w_unused_to_cycles;
  assign w_unused_to_cycles = (TO_CYCLES != 0);
  assign o_timeout_err      = 1'b0;
`endif

  always_comb begin
    w_state_nxt        = r_state;
    w_last_fetched_nxt = r_last_fetched;
    w_next_nxt         = r_next;
    w_count_nxt        = r_count;
    w_rcv_nxt          = r_rcv;
    w_rd_req_nxt       = r_rd_req;
    w_rd_addr_nxt      = r_rd_addr;
    w_rd_len_dw_nxt    = r_rd_len_dw;
    w_rd_3dw_nxt       = r_rd_3dw;
    w_ep_last_nxt      = r_ep_last;
    w_ep_last_upd_nxt  = 1'b0;
    w_err_unexp_nxt    = r_err_unexp;
`ifdef SONIC_DESC_FETCH_TIMEOUT_EN
    w_to_cnt_nxt       = r_to_cnt;
    w_timeout_err_nxt  = r_timeout_err;
`endif
    if (i_init) begin
      // Pointer parks on the last entry so the first fetch after init starts at index 0
      w_state_nxt        = StIdle;
      w_last_fetched_nxt = i_dt_size;
      w_rcv_nxt          = 6'd0;
      w_rd_req_nxt       = 1'b0;
      w_err_unexp_nxt    = 1'b0;
`ifdef SONIC_DESC_FETCH_TIMEOUT_EN
      w_to_cnt_nxt       = 32'd0;
      w_timeout_err_nxt  = 1'b0;
`endif
    end else begin
      if (i_cpl_desc_valid && (r_state != StWaitCpl)) w_err_unexp_nxt = 1'b1;
      unique case (r_state)
        StIdle: begin
          if (r_last_fetched != i_dt_rc_last) begin
            w_state_nxt     = StReq;
            w_next_nxt      = w_next;
            w_count_nxt     = w_count;
            w_rcv_nxt       = 6'd0;
            w_rd_req_nxt    = 1'b1;
            w_rd_addr_nxt   = w_addr;
            w_rd_len_dw_nxt = {2'b00, w_count, 2'b00};
            w_rd_3dw_nxt    = (w_addr[63:32] == 32'd0);
          end
        end
        StReq: begin
          if (i_rd_ack) begin
            w_rd_req_nxt = 1'b0;
            w_state_nxt  = StWaitCpl;
`ifdef SONIC_DESC_FETCH_TIMEOUT_EN
            w_to_cnt_nxt = 32'd0;
`endif
          end
        end
        StWaitCpl: begin
          if (i_cpl_desc_valid) begin
`ifdef SONIC_DESC_FETCH_TIMEOUT_EN
            w_to_cnt_nxt = 32'd0;
`endif
            if (w_rcv_inc == r_count) begin
              w_last_fetched_nxt = w_done_idx;
              w_ep_last_nxt      = w_done_idx;
              w_ep_last_upd_nxt  = 1'b1;
              w_rcv_nxt          = 6'd0;
              w_state_nxt        = StIdle;
            end else begin
              w_rcv_nxt = w_rcv_inc;
            end
          end
`ifdef SONIC_DESC_FETCH_TIMEOUT_EN
          else if (r_to_cnt == (TO_CYCLES - 32'd1)) begin
            // Drop the partial burst and reissue the identical request
            w_timeout_err_nxt = 1'b1;
            w_rcv_nxt         = 6'd0;
            w_to_cnt_nxt      = 32'd0;
            w_rd_req_nxt      = 1'b1;
            w_state_nxt       = StReq;
          end else begin
            w_to_cnt_nxt = r_to_cnt + 32'd1;
          end
`endif
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_last_fetched <= 16'd0;
      r_next         <= 16'd0;
      r_count        <= 6'd0;
      r_rcv          <= 6'd0;
      r_rd_req       <= 1'b0;
      r_rd_addr      <= 64'd0;
      r_rd_len_dw    <= 10'd0;
      r_rd_3dw       <= 1'b0;
      r_ep_last      <= 16'd0;
      r_ep_last_upd  <= 1'b0;
      r_err_unexp    <= 1'b0;
`ifdef SONIC_DESC_FETCH_TIMEOUT_EN
      r_to_cnt       <= 32'd0;
      r_timeout_err  <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_last_fetched <= w_last_fetched_nxt;
      r_next         <= w_next_nxt;
      r_count        <= w_count_nxt;
      r_rcv          <= w_rcv_nxt;
      r_rd_req       <= w_rd_req_nxt;
      r_rd_addr      <= w_rd_addr_nxt;
      r_rd_len_dw    <= w_rd_len_dw_nxt;
      r_rd_3dw       <= w_rd_3dw_nxt;
      r_ep_last      <= w_ep_last_nxt;
      r_ep_last_upd  <= w_ep_last_upd_nxt;
      r_err_unexp    <= w_err_unexp_nxt;
`ifdef SONIC_DESC_FETCH_TIMEOUT_EN
      r_to_cnt       <= w_to_cnt_nxt;
      r_timeout_err  <= w_timeout_err_nxt;
`endif
    end
  end

  assign o_rd_req        = r_rd_req;
  assign o_rd_addr       = r_rd_addr;
  assign o_rd_len_dw     = r_rd_len_dw;
  assign o_rd_3dw        = r_rd_3dw;
  assign o_ep_last       = r_ep_last;
  assign o_ep_last_upd   = r_ep_last_upd;
  assign o_err_unexp_cpl = r_err_unexp;

endmodule
